// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6,  S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB  = 4'd10, S_JEX   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Per-state Moore control word
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic state_t next_state(state_t s, logic [5:0] op);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = S_DECODE;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_RTYPEEX;
          OP_BEQ:       n = S_BEQEX;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JEX;
          default:      n = S_FETCH;  // unknown op retires as a NOP
        endcase
      S_MEMADR:  n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   n = S_MEMWB;
      S_RTYPEEX: n = S_RTYPEWB;
      S_ADDIEX:  n = S_ADDIWB;
      default:   n = S_FETCH;         // end states and illegal codes
    endcase
    return n;
  endfunction

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle; the controller is the master.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, regwrite, memwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps aluop/funct to the 3-bit ALU operation.
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Default to ADD so every unused code is still driven
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT:
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register, next-state, registered
// Moore control word, and the branch-resolving pcen term.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  multicycle_controller_if.master bus
);

  state_t state;
  state_t nxt;
  ctrl_t  ctl;

  assign nxt = next_state(state, bus.op);

  // State and its control word register together, so outputs are glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      ctl   <= state_ctrl(S_FETCH);
    end else begin
      state <= nxt;
      ctl   <= state_ctrl(nxt);
    end
  end

  aludec u_aludec (
    .aluop      (ctl.aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  // Strobes are gated by reset_n so nothing writes while reset is held;
  // zero is resolved in the same cycle, hence the combinational pcen.
  assign bus.pcen     = reset_n & (ctl.pcwrite | (ctl.branch & bus.zero));
  assign bus.irwrite  = reset_n & ctl.irwrite;
  assign bus.regwrite = reset_n & ctl.regwrite;
  assign bus.memwrite = reset_n & ctl.memwrite;
  assign bus.iord     = ctl.iord;
  assign bus.regdst   = ctl.regdst;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.pcsrc    = ctl.pcsrc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for the multicycle control unit.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] st();
    return dut.state;
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite};
  endfunction

  initial begin
    logic [5:0] fn  [6];
    logic [2:0] alu [6];
    fn[0] = 6'b100000; alu[0] = 3'b010;
    fn[1] = 6'b100010; alu[1] = 3'b110;
    fn[2] = 6'b100100; alu[2] = 3'b000;
    fn[3] = 6'b100101; alu[3] = 3'b001;
    fn[4] = 6'b101010; alu[4] = 3'b111;
    fn[5] = 6'b000000; alu[5] = 3'b010;

    bus.op = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b0;

    // reset held over edges
    repeat (3) tick();
    chk("rst_strobes", strobes(), 4'b0000);
    chk("rst_alu", bus.alucontrol, 3'b010);
    chk("rst_state", st(), 4'd0);
    chk("rst_alusrcb", bus.alusrcb, 2'b01);
    chk("rst_sel", {bus.iord, bus.alusrca, bus.pcsrc, bus.regdst, bus.memtoreg}, 6'b0);
    reset_n = 1'b1;
    #1;
    chk("rel_irwrite", bus.irwrite, 1'b1);
    chk("rel_pcen", bus.pcen, 1'b1);
    chk("rel_state", st(), 4'd0);

    // lw: 0,1,2,3,4 then FETCH
    tick(); chk("lw_s1", st(), 4'd1); chk("lw_dec_b", bus.alusrcb, 2'b11);
    chk("lw_dec_strb", strobes(), 4'b0000);
    tick(); chk("lw_s2", st(), 4'd2); chk("lw_adr_ab", {bus.alusrca, bus.alusrcb}, 3'b110);
    tick(); chk("lw_s3", st(), 4'd3); chk("lw_rd_iord", bus.iord, 1'b1);
    chk("lw_rd_strb", strobes(), 4'b0000);
    tick(); chk("lw_s4", st(), 4'd4);
    chk("lw_wb", {bus.regwrite, bus.memtoreg, bus.iord}, 3'b110);
    tick(); chk("lw_done", st(), 4'd0); chk("lw_done_rw", bus.regwrite, 1'b0);

    // R-type functs
    for (int i = 0; i < 6; i++) begin
      bus.op = 6'b000000; bus.funct = fn[i];
      tick();
      tick(); chk($sformatf("rt%0d_s6", i), st(), 4'd6);
      chk($sformatf("rt%0d_alu", i), bus.alucontrol, alu[i]);
      chk($sformatf("rt%0d_ex_strb", i), strobes(), 4'b0000);
      tick(); chk($sformatf("rt%0d_wb", i), {st(), bus.regwrite, bus.regdst}, {4'd7, 2'b11});
      tick(); chk($sformatf("rt%0d_done", i), st(), 4'd0);
    end

    // beq taken
    bus.op = 6'b000100; bus.zero = 1'b1; bus.funct = 6'b100101;
    tick(); chk("beq1_dec_pcen", bus.pcen, 1'b0);
    tick(); chk("beq1_s8", st(), 4'd8);
    chk("beq1_pc", {bus.pcen, bus.pcsrc}, 3'b101);
    chk("beq1_alu", bus.alucontrol, 3'b110);
    tick(); chk("beq1_done", st(), 4'd0);
    // beq not taken
    bus.zero = 1'b0;
    tick();
    tick(); chk("beq0_s8", st(), 4'd8); chk("beq0_pcen", bus.pcen, 1'b0);
    tick(); chk("beq0_done", st(), 4'd0);

    // sw
    bus.op = 6'b101011;
    tick();
    tick(); chk("sw_s2", st(), 4'd2); chk("sw_adr_mw", bus.memwrite, 1'b0);
    tick(); chk("sw_s5", st(), 4'd5);
    chk("sw_wr", {bus.memwrite, bus.irwrite, bus.iord, bus.regwrite}, 4'b1010);
    tick(); chk("sw_done", {st(), bus.memwrite}, 5'd0);

    // j
    bus.op = 6'b000010;
    tick();
    tick(); chk("j_s11", st(), 4'd11); chk("j_pc", {bus.pcen, bus.pcsrc}, 3'b110);
    tick(); chk("j_done", st(), 4'd0);

    // addi
    bus.op = 6'b001000;
    tick();
    tick(); chk("addi_s9", st(), 4'd9); chk("addi_ab", {bus.alusrca, bus.alusrcb}, 3'b110);
    tick(); chk("addi_wb", {st(), bus.regwrite, bus.regdst}, {4'd10, 2'b10});
    tick(); chk("addi_done", st(), 4'd0);

    // illegal op retires after decode
    bus.op = 6'b111111;
    tick(); chk("ill_s1", st(), 4'd1); chk("ill_strb", strobes(), 4'b0000);
    tick(); chk("ill_done", st(), 4'd0); chk("ill_fetch_ir", bus.irwrite, 1'b1);

    // reset mid RTYPEWB
    bus.op = 6'b000000; bus.funct = 6'b100000;
    tick(); tick(); tick();
    chk("mid_wb_rw", bus.regwrite, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strb", strobes(), 4'b0000);
    chk("mid_rst_state", st(), 4'd0);
    tick(); chk("mid_hold_strb", strobes(), 4'b0000);
    reset_n = 1'b1;
    #1;
    chk("mid_rel", {st(), bus.irwrite, bus.pcen}, {4'd0, 2'b11});
    tick(); chk("mid_next", st(), 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
